// File: rtl/sign_add_sub_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sign_add_sub_arbiter
// Brief    : Round-robin sequencer sharing one clocked signed add/sub unit
//            among NUM_REQ requesters. Optional macro SIGN_ADD_SUB_ARB_OVF_EN
//            registers a signed-overflow flag alongside each result.
// Revision : 1.0
// =============================================================================
module sign_add_sub_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int ALU_LATENCY     = 1,
    parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic [NUM_REQ-1:0]                 ReqValid,
    output logic [NUM_REQ-1:0]                 ReqReady,
    input  logic [NUM_REQ-1:0]                 ReqMode,
    input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqA,
    input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqB,
    output logic                               AluMode,
    output logic [INPUT_BIT_WIDTH-1:0]         AluA,
    output logic [INPUT_BIT_WIDTH-1:0]         AluB,
    input  logic [INPUT_BIT_WIDTH-1:0]         AluResult,
    output logic                               RespValid,
    input  logic                               RespReady,
    output logic [ID_WIDTH-1:0]                RespId,
    output logic [INPUT_BIT_WIDTH-1:0]         Result,
    output logic                               RespOverflow
);

    localparam int                    c_CNT_W   = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [c_CNT_W-1:0]    c_LAT     = c_CNT_W'(ALU_LATENCY);
    localparam logic [ID_WIDTH-1:0]   c_LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0]     c_NUM_REQ = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0]    c_ONE     = NUM_REQ'(1);
    localparam int                    c_MSB     = INPUT_BIT_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ID_WIDTH-1:0]          r_ptr;
    logic [c_CNT_W-1:0]           r_cnt;
    logic                         r_alu_mode;
    logic [INPUT_BIT_WIDTH-1:0]   r_alu_a;
    logic [INPUT_BIT_WIDTH-1:0]   r_alu_b;
    logic                         r_resp_valid;
    logic [ID_WIDTH-1:0]          r_resp_id;
    logic [INPUT_BIT_WIDTH-1:0]   r_result;

    logic [2*NUM_REQ-1:0]         w_req_dbl;
    logic [NUM_REQ-1:0]           w_req_rot;
    logic [ID_WIDTH-1:0]          w_off;
    logic [ID_WIDTH:0]            w_sum;
    logic [ID_WIDTH-1:0]          w_winner;
    logic [ID_WIDTH-1:0]          w_ptr_nxt;
    logic                         w_any;
    logic                         w_capture;
    logic [INPUT_BIT_WIDTH-1:0]   w_win_a;
    logic [INPUT_BIT_WIDTH-1:0]   w_win_b;

    // Rotate requests so bit k is requester (ptr + k) mod NUM_REQ; lowest set bit wins.
    assign w_req_dbl = {ReqValid, ReqValid} >> r_ptr;
    assign w_req_rot = w_req_dbl[NUM_REQ-1:0];
    assign w_any     = |ReqValid;

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = ID_WIDTH'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_winner  = (w_sum >= c_NUM_REQ) ? ID_WIDTH'(w_sum - c_NUM_REQ) : w_sum[ID_WIDTH-1:0];
    assign w_ptr_nxt = (w_winner == c_LAST_ID) ? '0 : w_winner + ID_WIDTH'(1);
    assign w_win_a   = ReqA[w_winner*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
    assign w_win_b   = ReqB[w_winner*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
    assign w_capture = (r_state == S_EXEC) && (r_cnt == c_LAT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ReqReady    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    ReqReady    = c_ONE << w_winner;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == c_LAT) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (RespReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_alu_mode   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_result     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_alu_mode <= ReqMode[w_winner];
                        r_alu_a    <= w_win_a;
                        r_alu_b    <= w_win_b;
                        r_resp_id  <= w_winner;
                        r_ptr      <= w_ptr_nxt;
                        r_cnt      <= '0;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_capture) begin
                        r_result     <= AluResult;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (RespReady) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIGN_ADD_SUB_ARB_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Subtraction overflows when operand signs differ; addition when they match.
    assign w_ovf = (r_alu_mode ? (r_alu_a[c_MSB] == r_alu_b[c_MSB])
                               : (r_alu_a[c_MSB] != r_alu_b[c_MSB]))
                   && (AluResult[c_MSB] != r_alu_a[c_MSB]);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_capture) begin
            r_ovf <= w_ovf;
        end
    end

    assign RespOverflow = r_ovf;
`else
    assign RespOverflow = 1'b0;
`endif

    assign AluMode   = r_alu_mode;
    assign AluA      = r_alu_a;
    assign AluB      = r_alu_b;
    assign RespValid = r_resp_valid;
    assign RespId    = r_resp_id;
    assign Result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sign_add_sub_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_sign_add_sub_arbiter
// Brief    : Scoreboard bench for sign_add_sub_arbiter with a clocked add/sub model.
// Revision : 1.0
// =============================================================================
module tb_sign_add_sub_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic [N-1:0]       ReqValid = '0;
    logic [N-1:0]       ReqReady;
    logic [N-1:0]       ReqMode = '0;
    logic [N*W-1:0]     ReqA = '0;
    logic [N*W-1:0]     ReqB = '0;
    logic               AluMode;
    logic [W-1:0]       AluA;
    logic [W-1:0]       AluB;
    logic [W-1:0]       AluResult = '0;
    logic               RespValid;
    logic               RespReady = 1'b1;
    logic [IDW-1:0]     RespId;
    logic [W-1:0]       Result;
    logic               RespOverflow;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   res;
        logic           ovf;
    } resp_t;

    resp_t exp_q[$];
    resp_t act_q[$];
    int    tests = 0;
    int    fails = 0;

    sign_add_sub_arbiter #(
        .NUM_REQ(N), .INPUT_BIT_WIDTH(W), .ALU_LATENCY(1), .ID_WIDTH(IDW)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqMode(ReqMode),
        .ReqA(ReqA), .ReqB(ReqB),
        .AluMode(AluMode), .AluA(AluA), .AluB(AluB), .AluResult(AluResult),
        .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
        .Result(Result), .RespOverflow(RespOverflow)
    );

    always #5 Clk = ~Clk;

    // Shared SignAddSub unit, one cycle of latency.
    always @(posedge Clk) AluResult <= AluMode ? AluA + AluB : AluA - AluB;

    always @(negedge Clk) begin
        if (!Reset && RespValid && RespReady)
            act_q.push_back(resp_t'{id: RespId, res: Result, ovf: RespOverflow});
    end

    function automatic resp_t model(input int id, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        resp_t r;
        int    full;
        full  = mode ? (int'($signed(a)) + int'($signed(b))) : (int'($signed(a)) - int'($signed(b)));
        r.id  = IDW'(id);
        r.res = W'(full);
`ifdef SIGN_ADD_SUB_ARB_OVF_EN
        r.ovf = (full > 127) || (full < -128);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    task automatic set_req(input int id, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        ReqMode[id]      = mode;
        ReqA[id*W +: W]  = a;
        ReqB[id*W +: W]  = b;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (ReqReady != '0) begin
                g = ReqReady;
                break;
            end
        end
    endtask

    task automatic issue(input int id, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [N-1:0] g);
        set_req(id, mode, a, b);
        @(posedge Clk); #1;
        ReqValid[id] = 1'b1;
        wait_grant(g);
        @(posedge Clk); #1;
        ReqValid[id] = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1; ReqValid = '0; RespReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic check_scoreboard();
        resp_t e, a;
        int    guard = 0;
        while (act_q.size() < exp_q.size() && guard < 60) begin
            @(negedge Clk);
            guard++;
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act_q.size() == 0) begin
                fails++;
                $display("FAIL resp_missing: got none, expected id=%0d res=%h ovf=%b", e.id, e.res, e.ovf);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL resp: got id=%0d res=%h ovf=%b, expected id=%0d res=%h ovf=%b",
                             a.id, a.res, a.ovf, e.id, e.res, e.ovf);
                end
            end
        end
        @(posedge Clk); #1;
        tests++;
        if (act_q.size() != 0) begin
            fails++;
            $display("FAIL resp_extra: got %0d unexpected responses, expected 0", act_q.size());
            act_q.delete();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge Clk);
        tests += 8;
        if (ReqReady !== '0)     begin fails++; $display("FAIL rst_ReqReady: got %b expected 0", ReqReady); end
        if (RespValid !== 1'b0)  begin fails++; $display("FAIL rst_RespValid: got %b expected 0", RespValid); end
        if (Result !== '0)       begin fails++; $display("FAIL rst_Result: got %h expected 0", Result); end
        if (RespId !== '0)       begin fails++; $display("FAIL rst_RespId: got %0d expected 0", RespId); end
        if (AluMode !== 1'b0)    begin fails++; $display("FAIL rst_AluMode: got %b expected 0", AluMode); end
        if (AluA !== '0)         begin fails++; $display("FAIL rst_AluA: got %h expected 0", AluA); end
        if (AluB !== '0)         begin fails++; $display("FAIL rst_AluB: got %h expected 0", AluB); end
        if (RespOverflow !== 1'b0) begin fails++; $display("FAIL rst_RespOverflow: got %b expected 0", RespOverflow); end
    endtask

    task automatic test_basic();
        logic [N-1:0] g;
        int lat = 0;
        set_req(0, 1'b1, 8'd20, 8'd8);
        exp_q.push_back(model(0, 1'b1, 8'd20, 8'd8));
        @(posedge Clk); #1;
        ReqValid = 4'b0001;
        @(negedge Clk);
        tests++;
        if (ReqReady !== 4'b0001) begin fails++; $display("FAIL basic_grant: got %b expected 0001", ReqReady); end
        @(posedge Clk); #1;
        ReqValid = '0;
        @(negedge Clk);
        tests++;
        if (ReqReady !== '0) begin fails++; $display("FAIL basic_ready_pulse: got %b expected 0000", ReqReady); end
        while (!RespValid && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        tests++;
        if (lat != 2) begin fails++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        check_scoreboard();

        exp_q.push_back(model(0, 1'b0, 8'd20, 8'd8));
        issue(0, 1'b0, 8'd20, 8'd8, g);
        tests++;
        if (g !== 4'b0001) begin fails++; $display("FAIL sub_grant: got %b expected 0001", g); end
        check_scoreboard();
    endtask

    task automatic test_sub_zero();
        logic [N-1:0] g;
        exp_q.push_back(model(2, 1'b0, 8'd100, 8'd100));
        issue(2, 1'b0, 8'd100, 8'd100, g);
        tests++;
        if (g !== 4'b0100) begin fails++; $display("FAIL zero_grant: got %b expected 0100", g); end
        check_scoreboard();
        exp_q.push_back(model(2, 1'b1, 8'd0, 8'd0));
        issue(2, 1'b1, 8'd0, 8'd0, g);
        tests++;
        if (g !== 4'b0100) begin fails++; $display("FAIL sole_grant: got %b expected 0100", g); end
        check_scoreboard();
    endtask

    task automatic test_overflow();
        logic [N-1:0] g;
        exp_q.push_back(model(1, 1'b1, 8'd100, 8'd100));
        issue(1, 1'b1, 8'd100, 8'd100, g);
        tests++;
        if (g !== 4'b0010) begin fails++; $display("FAIL ovf_add_grant: got %b expected 0010", g); end
        exp_q.push_back(model(3, 1'b0, 8'h80, 8'd1));
        issue(3, 1'b0, 8'h80, 8'd1, g);
        tests++;
        if (g !== 4'b1000) begin fails++; $display("FAIL ovf_sub_grant: got %b expected 1000", g); end
        check_scoreboard();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        int order [6] = '{0, 1, 2, 0, 3, 0};
        apply_reset();
        set_req(0, 1'b1, 8'd1, 8'd1);
        set_req(1, 1'b1, 8'd2, 8'd3);
        set_req(2, 1'b0, 8'd10, 8'd4);
        set_req(3, 1'b0, 8'd7, 8'd9);
        for (int i = 0; i < 6; i++)
            exp_q.push_back(model(order[i], ReqMode[order[i]], ReqA[order[i]*W +: W], ReqB[order[i]*W +: W]));
        @(posedge Clk); #1;
        ReqValid = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            wait_grant(g);
            tests++;
            if (g !== (4'b0001 << order[i])) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b expected %b", i, g, 4'b0001 << order[i]);
            end
            @(posedge Clk); #1;
            if (i == 3) ReqValid = 4'b1001;
            if (i == 5) ReqValid = 4'b0000;
        end
        check_scoreboard();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] g;
        int guard = 0;
        RespReady = 1'b0;
        exp_q.push_back(model(1, 1'b1, 8'd50, 8'hFD));
        exp_q.push_back(model(2, 1'b0, 8'd5, 8'd9));
        issue(1, 1'b1, 8'd50, 8'hFD, g);
        tests++;
        if (g !== 4'b0010) begin fails++; $display("FAIL bp_grant: got %b expected 0010", g); end
        set_req(2, 1'b0, 8'd5, 8'd9);
        ReqValid = 4'b0100;
        while (!RespValid && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            tests++;
            if (RespValid !== 1'b1 || Result !== 8'h2F || RespId !== 2'd1 || ReqReady !== '0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b res=%h id=%0d rdy=%b, expected v=1 res=2f id=1 rdy=0000",
                         i, RespValid, Result, RespId, ReqReady);
            end
        end
        @(posedge Clk); #1;
        RespReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        tests++;
        if (ReqReady !== 4'b0100 || RespValid !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_accept: got rdy=%b v=%b, expected rdy=0100 v=0", ReqReady, RespValid);
        end
        @(posedge Clk); #1;
        ReqValid = '0;
        check_scoreboard();
    endtask

    task automatic test_reset_mid_exec();
        logic [N-1:0] g;
        bit seen = 1'b0;
        issue(1, 1'b1, 8'd3, 8'd4, g);
        tests++;
        if (g !== 4'b0010) begin fails++; $display("FAIL mid_grant: got %b expected 0010", g); end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (RespValid !== 1'b0) seen = 1'b1;
        end
        tests += 2;
        if (seen) begin fails++; $display("FAIL mid_no_resp: got RespValid=1 expected 0"); end
        if (act_q.size() != 0) begin fails++; $display("FAIL mid_dropped: got %0d responses expected 0", act_q.size()); end
        set_req(0, 1'b1, 8'd9, 8'd9);
        exp_q.push_back(model(0, 1'b1, 8'd9, 8'd9));
        @(posedge Clk); #1;
        ReqValid = 4'b1111;
        wait_grant(g);
        tests++;
        if (g !== 4'b0001) begin fails++; $display("FAIL mid_ptr_reset: got %b expected 0001", g); end
        @(posedge Clk); #1;
        ReqValid = '0;
        check_scoreboard();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sub_zero();
        test_overflow();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_add_sub_arbiter.md
Name: sign_add_sub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one clocked signed add/sub unit (SignAddSub) between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the shared unit's mode and operand inputs and waits out its latency.
- Returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between requester logic and a single SignAddSub instance; it does not instantiate the unit.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- INPUT_BIT_WIDTH, 8, operand and result width in bits (two's complement).
- ALU_LATENCY, 1, clock cycles from stable operands at the unit inputs to a valid AluResult.
- ID_WIDTH, $clog2(NUM_REQ), width of RespId.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  NUM_REQ  per-requester request valid.
- ReqReady  output  NUM_REQ  per-requester accept; one-hot or zero.
- ReqMode  input  NUM_REQ  per-requester mode; 1 = add, 0 = subtract (A-B).
- ReqA  input  NUM_REQ*INPUT_BIT_WIDTH  operand A; requester i at [i*W +: W].
- ReqB  input  NUM_REQ*INPUT_BIT_WIDTH  operand B; same packing as ReqA.
- AluMode  output  1  to SignAddSub AddSubMode.
- AluA  output  INPUT_BIT_WIDTH  to SignAddSub InputA.
- AluB  output  INPUT_BIT_WIDTH  to SignAddSub InputB.
- AluResult  input  INPUT_BIT_WIDTH  from SignAddSub Result.
- RespValid  output  1  response valid.
- RespReady  input  1  response consumer ready.
- RespId  output  ID_WIDTH  index of the served requester.
- Result  output  INPUT_BIT_WIDTH  registered result.
- RespOverflow  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset values: state IDLE; ReqReady 0; AluMode 0; AluA 0; AluB 0; RespValid 0; RespId 0; Result 0; RespOverflow 0; RR pointer 0; latency counter 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the first set ReqValid bit scanning from the RR pointer upward, wrapping mod NUM_REQ.
  - ReqReady is combinational: (state==IDLE) & onehot(winner). It is never asserted in EXEC or RESP.
  - On an edge with any ReqValid set: latch the winner's ReqMode/ReqA/ReqB into AluMode/AluA/AluB and the winner index into RespId.
  - On the same edge: pointer <= winner+1 mod NUM_REQ, counter <= 0, state -> EXEC.
  - No ReqValid set: stay in IDLE; pointer unchanged.
- EXEC:
  - AluMode/AluA/AluB held stable.
  - Counter increments each cycle.
  - On the edge where counter==ALU_LATENCY: Result <= AluResult, RespValid <= 1, state -> RESP.
- Latency: RespValid rises ALU_LATENCY+1 cycles after the accept edge (2 cycles at default).
- RESP:
  - RespValid, RespId, Result, RespOverflow held stable until an edge with RespReady=1.
  - On that edge: RespValid <= 0, state -> IDLE.
  - No same-cycle bypass: the next accept happens at the earliest one cycle after the response handshake.
- Throughput: at most one operation per ALU_LATENCY+3 cycles at default.
- Alu outputs keep their last values in IDLE and RESP; they are not cleared.
- Arithmetic: result is modulo 2^INPUT_BIT_WIDTH, as produced by the unit. The block performs no arithmetic except overflow detection.
- Requester drops ReqValid while not yet granted: no effect, nothing latched.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped silently; all reset values apply on the next cycle.
- Sole requester: served every round regardless of pointer position.

Optional Feature:
- Macro: SIGN_ADD_SUB_ARB_OVF_EN.
- Defined: RespOverflow is registered together with Result.
  - Add: sign(A)==sign(B) and sign(Result)!=sign(A).
  - Sub: sign(A)!=sign(B) and sign(Result)!=sign(A).
  - A/B are the latched AluA/AluB.
- Not defined: RespOverflow is tied to 0 and no overflow logic is synthesized. The port is always present.

Test Plan:
- Req0 add A=20 B=8, RespReady=1 -> ReqReady[0] pulses 1 cycle; RespValid 2 cycles later with Result=28, RespId=0; sub A=20 B=8 -> Result=12.
- Req2 sub A=100 B=100 -> Result=0, RespId=2; then add 0,0 -> Result=0, RespOverflow=0.
- ReqValid=4'b0111 held continuously -> grants in order 0,1,2,0; then ReqValid=4'b1001 with pointer=1 -> grants 3, then 0.
- RespReady low for 5 cycles after a response -> RespValid, Result, RespId stable; ReqReady stays 0; one cycle after RespReady=1, the next pending request is accepted.
- Add A=100 B=100 -> Result=-56 (8'hC8); RespOverflow=1 with SIGN_ADD_SUB_ARB_OVF_EN, 0 without; sub A=-128 B=1 -> Result=127, overflow=1 with macro.
- Reset asserted one cycle into EXEC -> next cycle RespValid=0, state IDLE, pointer 0; no response is ever produced for the dropped operation.
